conv1d_engine: RTL



---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_window.sv | 51 +++++
 rtl/conv1d_engine.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and limits for the 1-D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } conv_state_t;

    localparam int unsigned MAX_TAPS = 8;

endpackage

// File: rtl/conv_window.sv
// Sample window, latched coefficients and multiply-add tree of the FIR.
// r_win[t] holds x[m+t]; r_win[0] is the oldest sample in the window.
module conv_window
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAPS   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [TAPS*DATA_W-1:0]   i_coeff,
    input  logic                     i_shift,
    input  logic [DATA_W-1:0]        i_din,
    output logic [DATA_W-1:0]        o_y
);

    logic [TAPS-1:0][DATA_W-1:0] r_win;
    logic [TAPS-1:0][DATA_W-1:0] r_coef;
    logic [TAPS:0][DATA_W-1:0]   w_next;
    logic [DATA_W-1:0]           w_sum;

    // New sample enters at the top; the concatenation keeps TAPS=1 legal.
    assign w_next = {i_din, r_win};

    // Latch coefficients at run start and shift the window on each valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win  <= '0;
            r_coef <= '0;
        end else begin
            if (i_load) begin
                r_coef <= i_coeff;
            end
            if (i_shift) begin
                r_win <= w_next[TAPS:1];
            end
        end
    end

    // Wrapping sum of products over the whole window.
    always_comb begin
        w_sum = '0;
        for (int unsigned t = 0; t < TAPS; t++) begin
            w_sum = w_sum + r_coef[t] * r_win[t];
        end
    end

    assign o_y = w_sum;

endmodule

// File: rtl/conv1d_engine.sv
// Run controller for the 1-D convolution: streams LEN words from v0,
// writes LEN-TAPS+1 FIR results to v1, reports busy/tdone.
module conv1d_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN    = 16,
    parameter int unsigned TAPS   = 3,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tstart,
    input  logic [TAPS*DATA_W-1:0]   coeff,
    output logic [ADDR_W-1:0]        v0_addr,
    output logic                     v0_rd_en,
    input  logic [DATA_W-1:0]        v0_rd_data,
    output logic [ADDR_W-1:0]        v1_addr,
    output logic                     v1_wr_en,
    output logic [DATA_W-1:0]        v1_wr_data,
    output logic                     busy,
    output logic                     tdone
);

    localparam logic [ADDR_W-1:0] LAST_RD  = ADDR_W'(LEN - 1);
    localparam logic [ADDR_W-1:0] FIRST_WR = ADDR_W'(TAPS - 1);

    if (TAPS < 1 || TAPS > MAX_TAPS || LEN < TAPS || 64'(LEN) > (64'd1 << ADDR_W)) begin : g_bad_params
        $error("conv1d_engine: illegal LEN/TAPS/ADDR_W combination");
    end

    conv_state_t        r_state;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_rd_en;
    logic               r_drain;
    logic               r_busy;
    logic               r_done;
    logic               r_vld1;
    logic [ADDR_W-1:0]  r_idx1;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               w_start;
    logic [ADDR_W:0]    w_diff;
    logic [DATA_W-1:0]  w_y;

    assign w_start = (r_state == IDLE) && tstart;

    // Borrow-out of (index - (TAPS-1)) tells whether the window is full yet.
    assign w_diff = {1'b0, r_idx1} - {1'b0, FIRST_WR};

    // Run FSM: read address sequencing, drain, completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_drain   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (tstart) begin
                        r_state   <= READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                READ: begin
                    if (r_rd_addr == LAST_RD) begin
                        r_state   <= DRAIN;
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                        r_drain   <= 1'b0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Track read data arrival and schedule the write once the window is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld1    <= 1'b0;
            r_idx1    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_vld1 <= r_rd_en;
            r_idx1 <= r_rd_addr;
            if (r_vld1 && !w_diff[ADDR_W]) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_diff[ADDR_W-1:0];
            end else begin
                r_wr_en   <= 1'b0;
                r_wr_addr <= '0;
            end
        end
    end

    conv_window #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start),
        .i_coeff (coeff),
        .i_shift (r_vld1),
        .i_din   (v0_rd_data),
        .o_y     (w_y)
    );

    assign v0_addr    = r_rd_addr;
    assign v0_rd_en   = r_rd_en;
    assign v1_addr    = r_wr_addr;
    assign v1_wr_en   = r_wr_en;
    assign v1_wr_data = r_wr_en ? w_y : '0;
    assign busy       = r_busy;
    assign tdone      = r_done;

endmodule
